// File: rtl/jzjpcc_memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, with a one-cycle read pipeline.
// Define JZJPCC_ARBITER_STARVATION_GUARD_EN to force a fetch grant after MAX_DATA_BURST conflicting data wins.
module jzjpcc_memory_arbiter #(
    parameter int RAM_A_WIDTH    = 12,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetchReq,
    input  logic [RAM_A_WIDTH-1:0] fetchAddr,
    output logic                   fetchGrant,
    output logic                   fetchValid,
    output logic [31:0]            fetchData,
    output logic                   stall_fetch,
    input  logic                   dataReq,
    input  logic                   dataWrite,
    input  logic [RAM_A_WIDTH-1:0] dataAddr,
    input  logic [31:0]            dataWriteData,
    input  logic [3:0]             dataByteEnable,
    output logic                   dataGrant,
    output logic                   dataValid,
    output logic [31:0]            dataReadData,
    output logic [RAM_A_WIDTH-1:0] ramAddr,
    output logic                   ramWriteEnable,
    output logic [3:0]             ramByteEnable,
    output logic [31:0]            ramWriteData,
    input  logic [31:0]            ramReadData
);

    typedef enum logic [1:0] {IDLE, FETCH_PEND, DATA_RD_PEND, DATA_WR_PEND} state_t;

    state_t state;
    logic   force_fetch;

    if (RAM_A_WIDTH < 1 || RAM_A_WIDTH > 29) begin : g_bad_addr_width
        $error("jzjpcc_memory_arbiter: RAM_A_WIDTH must be 1..29");
    end
    if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_bad_burst
        $error("jzjpcc_memory_arbiter: MAX_DATA_BURST must be 1..15");
    end

`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
    logic [3:0] conflict_count;

    assign force_fetch = fetchReq & dataReq & (conflict_count == 4'(MAX_DATA_BURST));

    // Counts consecutive cycles where data beat a waiting fetch; any fetch grant or idle fetch restarts it.
    always_ff @(posedge clock) begin
        if (reset || fetchGrant || !fetchReq)
            conflict_count <= '0;
        else if (dataGrant)
            conflict_count <= conflict_count + 4'd1;
    end
`else
    assign force_fetch = 1'b0;
`endif

    assign fetchGrant  = ~reset & fetchReq & (~dataReq | force_fetch);
    assign dataGrant   = ~reset & dataReq & ~force_fetch;
    assign stall_fetch = fetchReq & ~fetchGrant;

    always_comb begin
        ramAddr        = fetchAddr;
        ramWriteEnable = 1'b0;
        ramByteEnable  = 4'b0000;
        ramWriteData   = '0;
        if (dataGrant) begin
            ramAddr        = dataAddr;
            ramWriteEnable = dataWrite;
            ramByteEnable  = dataByteEnable;
            ramWriteData   = dataWriteData;
        end
    end

    // The state records who owns the RAM read port in the following cycle.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else if (fetchGrant)
            state <= FETCH_PEND;
        else if (dataGrant)
            state <= dataWrite ? DATA_WR_PEND : DATA_RD_PEND;
        else
            state <= IDLE;
    end

    // Valids are masked during reset so a response that was in flight is dropped.
    assign fetchValid   = ~reset & (state == FETCH_PEND);
    assign dataValid    = ~reset & ((state == DATA_RD_PEND) | (state == DATA_WR_PEND));
    assign fetchData    = fetchValid ? ramReadData : 32'h0;
    assign dataReadData = (~reset & (state == DATA_RD_PEND)) ? ramReadData : 32'h0;

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// Scoreboard bench for jzjpcc_memory_arbiter with a write-first RAM model.
// Expectations follow JZJPCC_ARBITER_STARVATION_GUARD_EN the same way the design does.
module tb_jzjpcc_memory_arbiter;

    localparam int AW   = 12;
    localparam int MAXB = 4;
`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam int K_NONE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;

    typedef struct {
        int          stamp;
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fetchReq = 1'b0;
    logic [AW-1:0] fetchAddr = '0;
    logic          fetchGrant, fetchValid, stall_fetch;
    logic [31:0]   fetchData;
    logic          dataReq = 1'b0;
    logic          dataWrite = 1'b0;
    logic [AW-1:0] dataAddr = '0;
    logic [31:0]   dataWriteData = '0;
    logic [3:0]    dataByteEnable = '0;
    logic          dataGrant, dataValid;
    logic [31:0]   dataReadData;
    logic [AW-1:0] ramAddr;
    logic          ramWriteEnable;
    logic [3:0]    ramByteEnable;
    logic [31:0]   ramWriteData;
    logic [31:0]   ramReadData = '0;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int model_cc = 0;

    logic [31:0] mem       [0:(1<<AW)-1];
    logic [31:0] model_mem [0:(1<<AW)-1];
    exp_t        sb[$];

    jzjpcc_memory_arbiter #(.RAM_A_WIDTH(AW), .MAX_DATA_BURST(MAXB)) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
        .fetchValid(fetchValid), .fetchData(fetchData), .stall_fetch(stall_fetch),
        .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr),
        .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
        .dataGrant(dataGrant), .dataValid(dataValid), .dataReadData(dataReadData),
        .ramAddr(ramAddr), .ramWriteEnable(ramWriteEnable), .ramByteEnable(ramByteEnable),
        .ramWriteData(ramWriteData), .ramReadData(ramReadData)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h0000_0013;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0103);
    endfunction

    // Write-first synchronous RAM: a read of the address being written returns the new word.
    logic [31:0] ram_word;
    always @(posedge clock) begin
        ram_word = mem[ramAddr];
        if (ramWriteEnable)
            for (int b = 0; b < 4; b++)
                if (ramByteEnable[b]) ram_word[8*b +: 8] = ramWriteData[8*b +: 8];
        if (ramWriteEnable) mem[ramAddr] <= ram_word;
        ramReadData <= ram_word;
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]       = init_word(i);
            model_mem[i] = init_word(i);
        end
    end

    // Drives one cycle of stimulus, predicts the grant and queues the response expected next cycle.
    task automatic step(input logic rst, input logic f, input logic [AW-1:0] fa,
                        input logic d, input logic w, input logic [AW-1:0] da,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic eg_f, output logic eg_d);
        exp_t e;
        logic forced;
        @(posedge clock);
        #1;
        reset = rst; fetchReq = f; fetchAddr = fa;
        dataReq = d; dataWrite = w; dataAddr = da; dataWriteData = wd; dataByteEnable = be;
        forced = GUARD && f && d && (model_cc == MAXB);
        eg_f = !rst && f && (!d || forced);
        eg_d = !rst && d && !forced;
        if (rst || eg_f || !f) model_cc = 0;
        else if (eg_d) model_cc++;
        e.stamp = cycle;
        e.kind  = K_NONE;
        e.data  = 32'h0;
        if (eg_f) begin
            e.kind = K_FETCH;
            e.data = model_mem[fa];
        end else if (eg_d && w) begin
            e.kind = K_STORE;
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[da][8*b +: 8] = wd[8*b +: 8];
        end else if (eg_d) begin
            e.kind = K_LOAD;
            e.data = model_mem[da];
        end
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input logic [AW-1:0] fa);
        logic gf, gd;
        step(1'b0, 1'b0, fa, 1'b0, 1'b0, '0, '0, 4'h0, gf, gd);
    endtask

    // Scoreboard side: the response queued last cycle must appear now, unless reset masks it.
    exp_t        mon_e;
    logic        mon_fv, mon_dv;
    logic [31:0] mon_fd, mon_dd;
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].stamp < cycle - 1) void'(sb.pop_front());
        if (sb.size() > 0 && sb[0].stamp == cycle - 1) begin
            mon_e  = sb.pop_front();
            mon_fv = !reset && (mon_e.kind == K_FETCH);
            mon_dv = !reset && (mon_e.kind == K_LOAD || mon_e.kind == K_STORE);
            mon_fd = mon_fv ? mon_e.data : 32'h0;
            mon_dd = mon_dv ? mon_e.data : 32'h0;
            checks += 4;
            if (fetchValid !== mon_fv) begin
                failures++;
                $display("[TB] FAIL sb_fetchValid cyc=%0d got=%b exp=%b", cycle, fetchValid, mon_fv);
            end
            if (fetchData !== mon_fd) begin
                failures++;
                $display("[TB] FAIL sb_fetchData cyc=%0d got=%h exp=%h", cycle, fetchData, mon_fd);
            end
            if (dataValid !== mon_dv) begin
                failures++;
                $display("[TB] FAIL sb_dataValid cyc=%0d got=%b exp=%b", cycle, dataValid, mon_dv);
            end
            if (dataReadData !== mon_dd) begin
                failures++;
                $display("[TB] FAIL sb_dataReadData cyc=%0d got=%h exp=%h", cycle, dataReadData, mon_dd);
            end
        end
    end

    task automatic test_reset();
        logic gf, gd;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 12'd5, 1'b1, 1'b1, 12'd9, 32'hFFFF_FFFF, 4'hF, gf, gd);
            checks += 4;
            if (fetchGrant !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetchGrant got=%b exp=0", fetchGrant); end
            if (dataGrant !== 1'b0) begin failures++; $display("[TB] FAIL reset_dataGrant got=%b exp=0", dataGrant); end
            if (ramWriteEnable !== 1'b0) begin failures++; $display("[TB] FAIL reset_ramWriteEnable got=%b exp=0", ramWriteEnable); end
            if (ramByteEnable !== 4'h0) begin failures++; $display("[TB] FAIL reset_ramByteEnable got=%h exp=0", ramByteEnable); end
        end
    endtask

    task automatic test_fetch();
        logic gf, gd;
        step(1'b0, 1'b1, 12'd5, 1'b0, 1'b0, '0, '0, 4'h0, gf, gd);
        checks += 4;
        if (fetchGrant !== 1'b1) begin failures++; $display("[TB] FAIL fetch_grant got=%b exp=1", fetchGrant); end
        if (dataGrant !== 1'b0) begin failures++; $display("[TB] FAIL fetch_dataGrant got=%b exp=0", dataGrant); end
        if (ramAddr !== 12'd5) begin failures++; $display("[TB] FAIL fetch_ramAddr got=%0d exp=5", ramAddr); end
        if (stall_fetch !== 1'b0) begin failures++; $display("[TB] FAIL fetch_stall got=%b exp=0", stall_fetch); end
        idle(12'd7);
        checks += 3;
        if (fetchData !== 32'h0000_0013) begin failures++; $display("[TB] FAIL fetch_data got=%h exp=00000013", fetchData); end
        if (ramAddr !== 12'd7) begin failures++; $display("[TB] FAIL idle_ramAddr got=%0d exp=7", ramAddr); end
        if (ramByteEnable !== 4'h0) begin failures++; $display("[TB] FAIL idle_ramByteEnable got=%h exp=0", ramByteEnable); end
        idle(12'd0);
        checks++;
        if (fetchValid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_one_cycle got=%b exp=0", fetchValid); end
    endtask

    task automatic test_store_load();
        logic gf, gd;
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 12'd9, 32'hDEAD_BEEF, 4'hF, gf, gd);
        checks += 4;
        if (dataGrant !== 1'b1) begin failures++; $display("[TB] FAIL store_grant got=%b exp=1", dataGrant); end
        if (ramWriteEnable !== 1'b1) begin failures++; $display("[TB] FAIL store_we got=%b exp=1", ramWriteEnable); end
        if (ramAddr !== 12'd9) begin failures++; $display("[TB] FAIL store_addr got=%0d exp=9", ramAddr); end
        if (ramWriteData !== 32'hDEAD_BEEF || ramByteEnable !== 4'hF) begin
            failures++; $display("[TB] FAIL store_fields got=%h/%h exp=deadbeef/f", ramWriteData, ramByteEnable);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 12'd9, '0, 4'hF, gf, gd);
        checks += 2;
        if (ramWriteEnable !== 1'b0) begin failures++; $display("[TB] FAIL load_we got=%b exp=0", ramWriteEnable); end
        if (dataValid !== 1'b1 || dataReadData !== 32'h0) begin
            failures++; $display("[TB] FAIL store_resp got=%b/%h exp=1/00000000", dataValid, dataReadData);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 12'd20, 32'h1234_5678, 4'h3, gf, gd);
        checks++;
        if (dataValid !== 1'b1 || dataReadData !== 32'hDEAD_BEEF) begin
            failures++; $display("[TB] FAIL load_resp got=%b/%h exp=1/deadbeef", dataValid, dataReadData);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 12'd20, '0, 4'hF, gf, gd);
        idle(12'd0);
        checks++;
        if (dataReadData !== ((init_word(20) & 32'hFFFF_0000) | 32'h0000_5678)) begin
            failures++; $display("[TB] FAIL partial_store got=%h exp=%h", dataReadData,
                                 (init_word(20) & 32'hFFFF_0000) | 32'h0000_5678);
        end
        idle(12'd0);
    endtask

    task automatic test_conflict();
        logic gf, gd;
        logic [9:0] pat;
        logic prev_f;
        pat = GUARD ? 10'b10_0001_0000 : 10'b0;
        prev_f = 1'b0;
        idle(12'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 12'd1, 1'b1, 1'b0, 12'd2, '0, 4'hF, gf, gd);
            checks += 4;
            if (fetchGrant !== pat[i]) begin failures++; $display("[TB] FAIL conflict_fetchGrant i=%0d got=%b exp=%b", i, fetchGrant, pat[i]); end
            if (dataGrant !== !pat[i]) begin failures++; $display("[TB] FAIL conflict_dataGrant i=%0d got=%b exp=%b", i, dataGrant, !pat[i]); end
            if (stall_fetch !== !pat[i]) begin failures++; $display("[TB] FAIL conflict_stall i=%0d got=%b exp=%b", i, stall_fetch, !pat[i]); end
            if (fetchValid !== prev_f) begin failures++; $display("[TB] FAIL conflict_fetchValid i=%0d got=%b exp=%b", i, fetchValid, prev_f); end
            prev_f = pat[i];
        end
        idle(12'd0);
    endtask

    task automatic test_conflict_clear();
        logic gf, gd;
        logic [8:0] pat;
        pat = GUARD ? 9'b1_0000_0000 : 9'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i != 3), 12'd3, 1'b1, 1'b0, 12'd4, '0, 4'hF, gf, gd);
            checks++;
            if (fetchGrant !== pat[i]) begin failures++; $display("[TB] FAIL clear_fetchGrant i=%0d got=%b exp=%b", i, fetchGrant, pat[i]); end
        end
        idle(12'd0);
    endtask

    task automatic test_back_to_back();
        logic gf, gd;
        logic          tf [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic          tw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0] ta [5] = '{12'd5, 12'd20, 12'd6, 12'd30, 12'd30};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, tf[i], ta[i], !tf[i], tw[i], ta[i], 32'hC0FF_EE00 + 32'(i), 4'hF, gf, gd);
            checks++;
            if (fetchGrant !== tf[i] || dataGrant !== !tf[i]) begin
                failures++; $display("[TB] FAIL b2b_grant i=%0d got=%b%b exp=%b%b", i, fetchGrant, dataGrant, tf[i], !tf[i]);
            end
        end
        idle(12'd0);
        checks++;
        if (dataReadData !== 32'hC0FF_EE03) begin failures++; $display("[TB] FAIL b2b_store_load got=%h exp=c0ffee03", dataReadData); end
        idle(12'd0);
    endtask

    task automatic test_reset_drop();
        logic gf, gd;
        step(1'b0, 1'b1, 12'd5, 1'b0, 1'b0, '0, '0, 4'h0, gf, gd);
        checks++;
        if (fetchGrant !== 1'b1) begin failures++; $display("[TB] FAIL drop_grant got=%b exp=1", fetchGrant); end
        step(1'b1, 1'b1, 12'd5, 1'b1, 1'b0, 12'd9, '0, 4'hF, gf, gd);
        checks += 2;
        if (fetchValid !== 1'b0) begin failures++; $display("[TB] FAIL drop_valid_n1 got=%b exp=0", fetchValid); end
        if (fetchGrant !== 1'b0 || dataGrant !== 1'b0) begin
            failures++; $display("[TB] FAIL drop_grants got=%b%b exp=00", fetchGrant, dataGrant);
        end
        step(1'b0, 1'b1, 12'd6, 1'b0, 1'b0, '0, '0, 4'h0, gf, gd);
        checks += 2;
        if (fetchValid !== 1'b0) begin failures++; $display("[TB] FAIL drop_valid_n2 got=%b exp=0", fetchValid); end
        if (fetchGrant !== 1'b1) begin failures++; $display("[TB] FAIL first_grant_after_reset got=%b exp=1", fetchGrant); end
        idle(12'd0);
        checks++;
        if (fetchData !== init_word(6)) begin failures++; $display("[TB] FAIL post_reset_fetch got=%h exp=%h", fetchData, init_word(6)); end
        idle(12'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_conflict();
        test_conflict_clear();
        test_back_to_back();
        test_reset_drop();
        idle(12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
